// File: rtl/pipeline_checker.sv
// rtl/pipeline_checker.sv - hardware monitor checking q equals d delayed by Depth enabled clocks
module pipeline_checker #(
  parameter int Width      = 15,
  parameter int Depth      = 2,
  parameter int CountWidth = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [Width-1:0]      d,
  input  logic [Width-1:0]      q,
  output logic                  checking,
  output logic                  error,
  output logic [CountWidth-1:0] check_count,
  output logic [15:0]           mismatch_count,
  output logic [Width-1:0]      first_err_exp,
  output logic [Width-1:0]      first_err_act,
  output logic [CountWidth-1:0] first_err_idx
);

  // A zero-depth checker still keeps a one-bit fill counter pinned at zero.
  localparam int FillW = (Depth > 0) ? $clog2(Depth + 1) : 1;
  localparam logic [FillW-1:0] FillFull = FillW'(Depth);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [FillW-1:0] fill_cnt;
  logic [FillW-1:0] fill_nxt;
  logic [Width-1:0] expected;
  logic             compare;
  logic             mismatch;

  // A compare happens on any enabled edge once the reference line is full.
  assign compare = enable && (fill_cnt == FillFull);

  generate
    if (Depth == 0) begin : g_pass
      assign expected = d;
    end else begin : g_line
      logic [Width-1:0] line [Depth];

      // Reference delay line advances only on enabled edges; contents need no reset.
      always_ff @(posedge clk) begin
        if (enable) begin
          line[0] <= d;
          for (int i = 1; i < Depth; i++) begin
            line[i] <= line[i-1];
          end
        end
      end

      assign expected = line[Depth-1];
    end
  endgenerate

  // Simulation treats any X/Z on q as a failure; hardware sees only 0/1.
`ifdef SYNTHESIS
  assign mismatch = (q != expected);
`else
  assign mismatch = (q !== expected);
`endif

  // Next fill level and state: a low enable always restarts the fill.
  always_comb begin
    fill_nxt  = fill_cnt;
    state_nxt = IDLE;
    if (!enable) begin
      fill_nxt  = '0;
      state_nxt = IDLE;
    end else begin
      if (fill_cnt != FillFull) begin
        fill_nxt = fill_cnt + FillW'(1);
      end
      state_nxt = (fill_nxt == FillFull) ? CHECK : FILL;
    end
  end

  // State and fill counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
    end
  end

  assign checking = (state == CHECK);

  // Compare bookkeeping: saturating counters, sticky error, first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      error          <= 1'b0;
      check_count    <= '0;
      mismatch_count <= '0;
      first_err_exp  <= '0;
      first_err_act  <= '0;
      first_err_idx  <= '0;
    end else if (compare) begin
      if (check_count != {CountWidth{1'b1}}) begin
        check_count <= check_count + CountWidth'(1);
      end
      if (mismatch) begin
        if (mismatch_count != 16'hFFFF) begin
          mismatch_count <= mismatch_count + 16'd1;
        end
        error <= 1'b1;
        if (!error) begin
          first_err_exp <= expected;
          first_err_act <= q;
          first_err_idx <= check_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_checker.sv
// tb/tb_pipeline_checker.sv - randomized directed bench for pipeline_checker against a history model
module tb_pipeline_checker;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [14:0] d;
  logic [14:0] qa;
  logic [14:0] qb;

  logic        a_checking, a_error;
  logic [31:0] a_check_count, a_first_err_idx;
  logic [15:0] a_mismatch_count;
  logic [14:0] a_first_err_exp, a_first_err_act;

  logic        b_checking, b_error;
  logic [4:0]  b_check_count, b_first_err_idx;
  logic [15:0] b_mismatch_count;
  logic [14:0] b_first_err_exp, b_first_err_act;

  int vectors;
  int miscompares;

  // Bench-side pipeline under check: register chain clocked every cycle.
  logic [14:0] pipe [4];

  // Reference model: full history of d over the current enabled streak.
  int          dep [2];
  longint      cmax [2];
  logic [14:0] hbuf [2][4096];
  int          hlen [2];
  logic        m_checking [2];
  logic        m_error [2];
  longint      m_cc [2];
  int          m_mc [2];
  logic [14:0] m_fexp [2];
  logic [14:0] m_fact [2];
  longint      m_fidx [2];

  pipeline_checker #(.Width(15), .Depth(2), .CountWidth(32)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .d(d), .q(qa),
    .checking(a_checking), .error(a_error), .check_count(a_check_count),
    .mismatch_count(a_mismatch_count), .first_err_exp(a_first_err_exp),
    .first_err_act(a_first_err_act), .first_err_idx(a_first_err_idx)
  );

  pipeline_checker #(.Width(15), .Depth(0), .CountWidth(5)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .d(d), .q(qb),
    .checking(b_checking), .error(b_error), .check_count(b_check_count),
    .mismatch_count(b_mismatch_count), .first_err_exp(b_first_err_exp),
    .first_err_act(b_first_err_act), .first_err_idx(b_first_err_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hlen[i] = 0; m_checking[i] = 0; m_error[i] = 0; m_cc[i] = 0; m_mc[i] = 0;
      m_fexp[i] = '0; m_fact[i] = '0; m_fidx[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input logic en, input logic [14:0] dv, input logic [14:0] qv);
    logic [14:0] exp;
    if (!en) begin
      hlen[i] = 0;
      m_checking[i] = 0;
    end else begin
      if (hlen[i] >= dep[i]) begin
        exp = (dep[i] == 0) ? dv : hbuf[i][hlen[i] - dep[i]];
        if (qv !== exp) begin
          if (m_mc[i] < 65535) m_mc[i]++;
          if (!m_error[i]) begin
            m_fexp[i] = exp; m_fact[i] = qv; m_fidx[i] = m_cc[i];
          end
          m_error[i] = 1;
        end
        if (m_cc[i] < cmax[i]) m_cc[i]++;
      end
      hbuf[i][hlen[i]] = dv;
      hlen[i]++;
      m_checking[i] = (hlen[i] >= dep[i]);
    end
  endtask

  task automatic check_all();
    chk("a_checking", 32'(a_checking), 32'(m_checking[0]));
    chk("a_error", 32'(a_error), 32'(m_error[0]));
    chk("a_check_count", a_check_count, m_cc[0][31:0]);
    chk("a_mismatch_count", 32'(a_mismatch_count), 32'(m_mc[0]));
    chk("a_first_err_exp", 32'(a_first_err_exp), 32'(m_fexp[0]));
    chk("a_first_err_act", 32'(a_first_err_act), 32'(m_fact[0]));
    chk("a_first_err_idx", a_first_err_idx, m_fidx[0][31:0]);
    chk("b_checking", 32'(b_checking), 32'(m_checking[1]));
    chk("b_error", 32'(b_error), 32'(m_error[1]));
    chk("b_check_count", 32'(b_check_count), m_cc[1][31:0]);
    chk("b_mismatch_count", 32'(b_mismatch_count), 32'(m_mc[1]));
    chk("b_first_err_exp", 32'(b_first_err_exp), 32'(m_fexp[1]));
    chk("b_first_err_act", 32'(b_first_err_act), 32'(m_fact[1]));
    chk("b_first_err_idx", 32'(b_first_err_idx), m_fidx[1][31:0]);
  endtask

  // One clock: lat selects the pipeline length feeding qa; fa/fb flip q bits.
  task automatic step(input logic en, input logic [14:0] dv, input int lat,
                      input logic [14:0] fa, input logic [14:0] fb);
    enable = en;
    d      = dv;
    qa     = ((lat == 0) ? dv : pipe[lat-1]) ^ fa;
    qb     = dv ^ fb;
    model_edge(0, en, dv, qa);
    model_edge(1, en, dv, qb);
    @(posedge clk);
    #1;
    for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = dv;
    check_all();
  endtask

  // Reset asserted together with enable: reset must win.
  task automatic do_reset();
    rst    = 1;
    enable = 1;
    d      = 15'($urandom);
    qa     = 15'($urandom);
    qb     = 15'($urandom);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    for (int k = 0; k < 4; k++) pipe[k] = '0;
    check_all();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clk = 0; rst = 1; enable = 0; d = '0; qa = '0; qb = '0;
    dep[0] = 2; dep[1] = 0;
    cmax[0] = 64'hFFFF_FFFF; cmax[1] = 31;
    model_reset();

    // Reset state.
    do_reset();
    chk("reset_a_count", a_check_count, 32'd0);
    chk("reset_a_checking", 32'(a_checking), 32'd0);

    // Matching pipeline, 100 enabled edges of random data.
    for (int e = 0; e < 100; e++) begin
      step(1, 15'($urandom), 2, '0, '0);
      if (e == 0) chk("fill_checking_e1", 32'(a_checking), 32'd0);
      if (e == 1) chk("fill_checking_e2", 32'(a_checking), 32'd1);
      if (e == 2) chk("first_compare", a_check_count, 32'd1);
    end
    chk("match_count", a_check_count, 32'd98);
    chk("match_mism", 32'(a_mismatch_count), 32'd0);
    chk("match_error", 32'(a_error), 32'd0);
    chk("b_saturate", 32'(b_check_count), 32'd31);

    // Wrong latency: 3-stage pipeline against a depth-2 checker.
    do_reset();
    for (int e = 0; e < 6; e++) begin
      step(1, 15'(e + 1), 3, '0, '0);
      if (e == 2) begin
        chk("lat_error", 32'(a_error), 32'd1);
        chk("lat_exp", 32'(a_first_err_exp), 32'd1);
        chk("lat_act", 32'(a_first_err_act), 32'd0);
        chk("lat_idx", a_first_err_idx, 32'd0);
      end
    end

    // Single bit flip on compare 10 of 50.
    do_reset();
    for (int e = 0; e < 52; e++) begin
      step(1, 15'($urandom), 2, (e == 12) ? 15'h1 : 15'h0, '0);
    end
    chk("flip_mism", 32'(a_mismatch_count), 32'd1);
    chk("flip_idx", a_first_err_idx, 32'd10);
    chk("flip_error", 32'(a_error), 32'd1);
    chk("flip_count", a_check_count, 32'd50);

    // Enable gap of 5 edges, refill, then resume.
    for (int e = 0; e < 5; e++) begin
      step(0, 15'($urandom), 2, '0, '0);
      if (e == 0) chk("gap_checking", 32'(a_checking), 32'd0);
    end
    chk("gap_count", a_check_count, 32'd50);
    for (int e = 0; e < 2; e++) step(1, 15'($urandom), 2, '0, '0);
    chk("refill_count", a_check_count, 32'd50);
    chk("refill_checking", 32'(a_checking), 32'd1);
    for (int e = 0; e < 10; e++) step(1, 15'($urandom), 2, '0, '0);
    chk("resume_count", a_check_count, 32'd60);
    chk("resume_mism", 32'(a_mismatch_count), 32'd1);

    // Depth 0: pass-through, then inverted q.
    do_reset();
    for (int e = 0; e < 20; e++) step(1, 15'($urandom), 2, '0, '0);
    chk("d0_count", 32'(b_check_count), 32'd20);
    chk("d0_error", 32'(b_error), 32'd0);
    for (int e = 0; e < 5; e++) begin
      step(1, 15'($urandom), 2, '0, 15'h7FFF);
      chk("d0_inv_mism", 32'(b_mismatch_count), 32'(e + 1));
    end

    // Reset mid-run with error set and enable high, then refill.
    step(1, 15'($urandom), 2, 15'h4, '0);
    chk("pre_reset_error", 32'(a_error), 32'd1);
    do_reset();
    chk("post_reset_error", 32'(a_error), 32'd0);
    chk("post_reset_b_mism", 32'(b_mismatch_count), 32'd0);
    for (int e = 0; e < 3; e++) begin
      step(1, 15'($urandom), 2, '0, '0);
      if (e == 1) chk("post_reset_refill", a_check_count, 32'd0);
    end
    chk("post_reset_first", a_check_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
